multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Sequencing controller for the multicycle variant of the processor datapath.
- Replaces the single-cycle opcode decoder with a state machine that issues per-cycle datapath enables across fetch, decode, execute, memory and writeback.
- Stalls on a memory-ready handshake so that one shared memory serves both instruction and data accesses.
- Keeps a retired-instruction counter for bring-up.

Parameters:
- OPC_LW, 6'd0, load word opcode
- OPC_SW, 6'd1, store word opcode
- OPC_J, 6'd2, jump opcode
- OPC_BEQ, 6'd4, branch-if-equal opcode
- OPC_RTYPE, 6'd10, R-type opcode
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  opcode field from instruction register (valid from DECODE onward)
- mem_ready  in  1  shared memory completed current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by ALU zero (branch)
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  writeback select: 1=MDR, 0=ALUOut
- RegDst  out  1  destination register: 1=rd, 0=rt
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0=PC, 1=regA
- ALUSrcB  out  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- ALUOp  out  2  00=add, 01=sub, 10=funct-decoded
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- state_o  out  4  current state encoding (debug)
- instr_count  out  CNT_W  retired instruction count

Behaviour:
- Clock and reset: single clock `clk`; reset is synchronous and active-high on `reset`. While reset is sampled high, state goes to IDLE and instr_count goes to 0.
- Outputs in IDLE: all control outputs are 0.
- Output timing: outputs are Moore-decoded from the state register, except the mem_ready-qualified signals listed below. Signals not listed for a state are 0.
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, TRAP=11.
- IDLE: outputs all 0. Always go to FETCH next cycle, so the first fetch occurs 1 cycle after reset deasserts.
- FETCH:
  - Assert MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite are asserted only when mem_ready=1.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - Assert ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
  - Next state by opcode: LW/SW->MEMADR, RTYPE->EXEC, BEQ->BRANCH, J->JUMP, other->illegal handling (see Optional Feature).
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is MEMRD if LW, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Retire; go to FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold until mem_ready=1, then retire and go to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Retire; go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Retire; go to FETCH.
- JUMP: PCWrite=1, PCSource=10. Retire; go to FETCH.
- Retire: instr_count increments by 1 on the cycle that leaves a retiring state. It wraps from all-ones to 0 with no flag.
- Memory strobes: MemRead and MemWrite are never both 1. Each holds steady for the whole stall.
- Register-file timing: RegWrite is asserted for exactly one cycle per writeback.
- Opcode sampling: opcode is sampled only in DECODE and MEMADR. Changes in other states are ignored.
- Reset mid-operation: reset in any state (including mid-stall) forces IDLE on the next edge. No write strobe is asserted in the cycle following reset.
- Instruction latencies with mem_ready tied 1: LW 5, SW 4, RTYPE 4, BEQ 3, J 3 cycles. Each stalled cycle adds 1.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an unrecognized opcode in DECODE goes to TRAP.
  - TRAP holds all outputs 0 and is not counted as a retire.
  - TRAP is exited only by reset.
  - state_o=11 serves as the trap indication.
- Not defined: an unrecognized opcode is treated as NOP. DECODE goes directly to FETCH, and instr_count increments.
- TRAP encoding is unreachable in this build.

Test Plan:
- Reset/startup: assert reset 2 cycles with mem_ready=1, then release -> IDLE, outputs 0, instr_count=0; FETCH on the next cycle with MemRead=1, IRWrite=1, PCWrite=1.
- LW: opcode=0, mem_ready=1 -> states 1,2,3,4,5,1; RegWrite=1 and MemtoReg=1 only in MEMWB; instr_count=1.
- SW with stall: opcode=1, mem_ready=0 for 3 cycles in MEMWR -> MemWrite=1 held 4 cycles, IorD=1; no RegWrite; count +1.
- RTYPE, BEQ, J back-to-back, mem_ready=1 -> total 4+3+3=10 cycles; ALUOp 10/01/--; PCWriteCond=1 only in BRANCH; PCSource=10 in JUMP; count=3.
- Fetch stall: mem_ready=0 for 5 cycles in FETCH -> IRWrite=0 and PCWrite=0 throughout; both 1 on the first mem_ready=1 cycle.
- Illegal opcode 6'd63 -> with ILLEGAL_TRAP_EN: state_o=11 held, count unchanged, reset recovers to IDLE; without: returns to FETCH after DECODE, count +1.
- Reset mid-MEMRD stall -> next state IDLE, MemRead=0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Sequencing controller for the multicycle datapath. It issues per-cycle
//   datapath enables across fetch, decode, execute, memory and writeback.
//   It stalls on mem_ready so that one shared memory can serve both
//   instruction and data accesses, and it counts retired instructions.
//
//   Build option: define ILLEGAL_TRAP_EN to send unrecognised opcodes to a
//   sticky TRAP state, which only reset clears. When the macro is undefined,
//   an unrecognised opcode retires as a NOP.
module multicycle_control_fsm #(
    parameter logic [5:0]  OPC_LW    = 6'd0,
    parameter logic [5:0]  OPC_SW    = 6'd1,
    parameter logic [5:0]  OPC_J     = 6'd2,
    parameter logic [5:0]  OPC_BEQ   = 6'd4,
    parameter logic [5:0]  OPC_RTYPE = 6'd10,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_retire;
    logic [CNT_W-1:0] r_count;

    // State register; reset returns to IDLE from any state, including mid-stall
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Retired-instruction counter; it wraps silently
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Next-state, retire and Moore control decode (FETCH strobes qualified by mem_ready)
    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;

        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                if (opcode == OPC_LW || opcode == OPC_SW) begin
                    w_next = S_MEMADR;
                end else if (opcode == OPC_RTYPE) begin
                    w_next = S_EXEC;
                end else if (opcode == OPC_BEQ) begin
                    w_next = S_BRANCH;
                end else if (opcode == OPC_J) begin
                    w_next = S_JUMP;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    w_next   = S_TRAP;
`else
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
`endif
                end
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = (opcode == OPC_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                w_next = S_TRAP;
`else
                w_next = S_IDLE;
`endif
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign state_o     = r_state;
    assign instr_count = r_count;

endmodule
